// File: rtl/fp_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : fp_pkg                                                            |
// | Desc   : binary32 field constants, canonical values and FP class type.     |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package fp_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] POS_ZERO   = 32'h0000_0000;
   localparam logic [31:0] NEG_ZERO   = 32'h8000_0000;

   typedef enum logic [2:0] {
      ZERO    = 3'd0,
      SUBNORM = 3'd1,
      NORMAL  = 3'd2,
      INF     = 3'd3,
      QNAN    = 3'd4,
      SNAN    = 3'd5
   } fp_class_e;

   function automatic fp_class_e fp_class_of(input logic [31:0] v);
      logic [EXP_W-1:0]  e;
      logic [FRAC_W-1:0] f;
      e = v[30:23];
      f = v[22:0];
      if (e == EXP_MAX)
         fp_class_of = (f == '0) ? INF : (f[FRAC_W-1] ? QNAN : SNAN);
      else if (e == '0)
         fp_class_of = (f == '0) ? ZERO : SUBNORM;
      else
         fp_class_of = NORMAL;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fp_feq_cmp_if.sv
// +----------------------------------------------------------------------------+
// | Module : fp_feq_cmp_if                                                     |
// | Desc   : operand/result bundle for the FEQ.S compare unit.                 |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fp_feq_cmp_if #(
   parameter int XLEN = 32,
   parameter int FLEN = 32
);
   logic [FLEN-1:0] a;
   logic [FLEN-1:0] b;
   logic [XLEN-1:0] y;
   logic            nv;

   modport master (output a, output b, input  y, input  nv);
   modport slave  (input  a, input  b, output y, output nv);
endinterface

`default_nettype wire

// File: rtl/fp_classify.sv
// +----------------------------------------------------------------------------+
// | Module : fp_classify                                                       |
// | Desc   : combinational binary32 operand classifier (shared by FP compares).|
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp_classify
   import fp_pkg::*;
(
   input  wire logic [31:0] i_val,
   output logic             o_is_zero,
   output logic             o_is_subnorm,
   output logic             o_is_inf,
   output logic             o_is_qnan,
   output logic             o_is_snan
);

   logic [EXP_W-1:0]  w_exp;
   logic [FRAC_W-1:0] w_frac;
   logic              w_exp_max;
   logic              w_exp_zero;
   logic              w_frac_zero;

   assign w_exp       = i_val[30:23];
   assign w_frac      = i_val[22:0];
   assign w_exp_max   = (w_exp == EXP_MAX);
   assign w_exp_zero  = (w_exp == '0);
   assign w_frac_zero = (w_frac == '0);

   assign o_is_zero    = w_exp_zero &  w_frac_zero;
   assign o_is_subnorm = w_exp_zero & ~w_frac_zero;
   assign o_is_inf     = w_exp_max  &  w_frac_zero;
   assign o_is_qnan    = w_exp_max  & ~w_frac_zero &  w_frac[FRAC_W-1];
   assign o_is_snan    = w_exp_max  & ~w_frac_zero & ~w_frac[FRAC_W-1];

endmodule

`default_nettype wire

// File: rtl/fp_feq_cmp.sv
// +----------------------------------------------------------------------------+
// | Module : fp_feq_cmp                                                        |
// | Desc   : registered RISC-V FEQ.S comparator with NV flag, 1-cycle latency. |
// |          Define FEQ_DAZ_EN to treat subnormal operands as signed zero.     |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp_feq_cmp
   import fp_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int FLEN = 32
)(
   input  wire logic      clk,
   input  wire logic      rst,
   fp_feq_cmp_if.slave    bus
);

   logic a_zero, a_sub, a_inf, a_qnan, a_snan;
   logic b_zero, b_sub, b_inf, b_qnan, b_snan;

   fp_classify u_cls_a (
      .i_val        (bus.a),
      .o_is_zero    (a_zero),
      .o_is_subnorm (a_sub),
      .o_is_inf     (a_inf),
      .o_is_qnan    (a_qnan),
      .o_is_snan    (a_snan)
   );

   fp_classify u_cls_b (
      .i_val        (bus.b),
      .o_is_zero    (b_zero),
      .o_is_subnorm (b_sub),
      .o_is_inf     (b_inf),
      .o_is_qnan    (b_qnan),
      .o_is_snan    (b_snan)
   );

   logic a_eff_zero, b_eff_zero;
   logic any_nan, same_inf, bits_eq;
   logic eq_d, eq_q;
   logic nv_d, nv_q;

`ifdef FEQ_DAZ_EN
   assign a_eff_zero = a_zero | a_sub;
   assign b_eff_zero = b_zero | b_sub;
`else
   assign a_eff_zero = a_zero;
   assign b_eff_zero = b_zero;
   logic unused_sub;
   assign unused_sub = a_sub ^ b_sub;
`endif

   assign any_nan  = a_qnan | a_snan | b_qnan | b_snan;
   assign same_inf = a_inf & b_inf & (bus.a[FLEN-1] == bus.b[FLEN-1]);
   assign bits_eq  = (bus.a == bus.b);

   // NaN dominates; otherwise signed zeros match, else exact bit equality.
   always_comb begin
      eq_d = 1'b0;
      nv_d = a_snan | b_snan;
      if (!any_nan)
         eq_d = (a_eff_zero & b_eff_zero) | same_inf | bits_eq;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eq_q <= 1'b0;
         nv_q <= 1'b0;
      end else begin
         eq_q <= eq_d;
         nv_q <= nv_d;
      end
   end

   assign bus.y  = {{(XLEN-1){1'b0}}, eq_q};
   assign bus.nv = nv_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_feq_cmp.sv
// +----------------------------------------------------------------------------+
// | Module : tb_fp_feq_cmp                                                     |
// | Desc   : directed self-checking bench for fp_feq_cmp.                      |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fp_feq_cmp;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fp_feq_cmp_if #(.XLEN(32), .FLEN(32)) bus ();

   fp_feq_cmp #(.XLEN(32), .FLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      bus.a = 32'h3F80_0000;
      bus.b = 32'h3F80_0000;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.y !== 32'h0 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL reset: y=%h nv=%b expected y=00000000 nv=0", bus.y, bus.nv);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_zero();
      bus.a = 32'h0000_0000;
      bus.b = 32'h8000_0000;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h1 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL pos_neg_zero: y=%h nv=%b expected y=00000001 nv=0", bus.y, bus.nv);
      end
   endtask

   task automatic test_equal();
      bus.a = 32'h3F80_0000;
      bus.b = 32'h3F80_0000;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h1 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL one_eq_one: y=%h nv=%b expected y=00000001 nv=0", bus.y, bus.nv);
      end
      bus.b = 32'h4000_0000;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h0 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL one_ne_two: y=%h nv=%b expected y=00000000 nv=0", bus.y, bus.nv);
      end
   endtask

   task automatic test_qnan();
      bus.a = 32'h7FC0_0000;
      bus.b = 32'h3F80_0000;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h0 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL qnan_vs_one: y=%h nv=%b expected y=00000000 nv=0", bus.y, bus.nv);
      end
      bus.b = 32'h7FC0_0000;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h0 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL qnan_vs_qnan: y=%h nv=%b expected y=00000000 nv=0", bus.y, bus.nv);
      end
   endtask

   task automatic test_snan_inf();
      bus.a = 32'h7F80_0001;
      bus.b = 32'h7F80_0001;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h0 || bus.nv !== 1'b1) begin
         errors++;
         $display("FAIL snan_vs_snan: y=%h nv=%b expected y=00000000 nv=1", bus.y, bus.nv);
      end
      bus.a = 32'h7F80_0000;
      bus.b = 32'hFF80_0000;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h0 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL pinf_vs_ninf: y=%h nv=%b expected y=00000000 nv=0", bus.y, bus.nv);
      end
      bus.b = 32'h7F80_0000;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h1 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL pinf_vs_pinf: y=%h nv=%b expected y=00000001 nv=0", bus.y, bus.nv);
      end
      // sNaN in b only, with a quiet NaN in a: flag still raised
      bus.a = 32'h7FC0_0000;
      bus.b = 32'hFFBF_FFFF;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h0 || bus.nv !== 1'b1) begin
         errors++;
         $display("FAIL qnan_vs_snan: y=%h nv=%b expected y=00000000 nv=1", bus.y, bus.nv);
      end
   endtask

   task automatic test_subnorm();
      logic [31:0] exp_y;
`ifdef FEQ_DAZ_EN
      exp_y = 32'h1;
`else
      exp_y = 32'h0;
`endif
      bus.a = 32'h0000_0001;
      bus.b = 32'h0000_0000;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== exp_y || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL subnorm_vs_zero: y=%h nv=%b expected y=%h nv=0", bus.y, bus.nv, exp_y);
      end
      bus.a = 32'h8040_0000;
      bus.b = 32'h8040_0000;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h1 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL subnorm_same: y=%h nv=%b expected y=00000001 nv=0", bus.y, bus.nv);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [6];
      logic [31:0] vb [6];
      logic [31:0] ey [6];
      logic        en [6];
      va[0] = 32'h4049_0FDB; vb[0] = 32'h4049_0FDB; ey[0] = 32'h1; en[0] = 1'b0;
      va[1] = 32'h4049_0FDB; vb[1] = 32'hC049_0FDB; ey[1] = 32'h0; en[1] = 1'b0;
      va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; ey[2] = 32'h1; en[2] = 1'b0;
      va[3] = 32'hFF80_0001; vb[3] = 32'h3F80_0000; ey[3] = 32'h0; en[3] = 1'b1;
      va[4] = 32'hFFC0_0000; vb[4] = 32'hFFC0_0000; ey[4] = 32'h0; en[4] = 1'b0;
      va[5] = 32'h0080_0000; vb[5] = 32'h0080_0001; ey[5] = 32'h0; en[5] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.a = va[i];
         bus.b = vb[i];
         @(posedge clk); #1;
         checks++;
         if (bus.y !== ey[i] || bus.nv !== en[i]) begin
            errors++;
            $display("FAIL b2b[%0d]: y=%h nv=%b expected y=%h nv=%b", i, bus.y, bus.nv, ey[i], en[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      bus.a = 32'h3F80_0000;
      bus.b = 32'h3F80_0000;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h1 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset: y=%h nv=%b expected y=00000001 nv=0", bus.y, bus.nv);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.y !== 32'h0 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: y=%h nv=%b expected y=00000000 nv=0", bus.y, bus.nv);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.y !== 32'h1 || bus.nv !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: y=%h nv=%b expected y=00000001 nv=0", bus.y, bus.nv);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      bus.a  = '0;
      bus.b  = '0;
      test_reset();
      test_zero();
      test_equal();
      test_qnan();
      test_snan_inf();
      test_subnorm();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
